// File: rtl/osc_trigger_capture_if.sv
// Sample, trigger-control and readout signals of the oscilloscope capture block.
// master = sample source / readout consumer, slave = capture engine.
// Pure wiring, no latency; flow is strobe-driven, there is no backpressure.
interface osc_trigger_capture_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  arm;
    logic                  force_trig;
    logic [DATA_WIDTH-1:0] trig_level;
    logic                  trig_slope;
    logic [ADDR_WIDTH-1:0] pretrig;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  busy;
    logic                  triggered;
    logic                  done;

    modport master (
        output s_valid, s_data, arm, force_trig, trig_level, trig_slope, pretrig, rd_en,
        input  rd_data, rd_valid, rd_last, busy, triggered, done
    );

    modport slave (
        input  s_valid, s_data, arm, force_trig, trig_level, trig_slope, pretrig, rd_en,
        output rd_data, rd_valid, rd_last, busy, triggered, done
    );
endinterface

// File: rtl/osc_trigger_capture.sv
// Level/edge-triggered circular capture of ADC samples with pre-trigger depth and time-ordered readout.
// Readout latency: rd_data/rd_valid one cycle after rd_en (synchronous RAM read).
// No backpressure: samples outside a capture and reads outside DONE are dropped.
module osc_trigger_capture #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10
) (
    input  logic ACLK,
    input  logic ARESETN,
    osc_trigger_capture_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_FILL,
        S_WAIT_TRIG,
        S_POST,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_q;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_trig_ptr;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_post_rem;
    logic [ADDR_WIDTH-1:0] r_rd_cnt;
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_valid;
    logic                  r_force_pend;
    logic                  r_triggered;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_rd_valid;
    logic                  r_rd_last;

    logic                  w_capturing;
    logic                  w_accept;
    logic                  w_rd_fire;
    logic                  w_level_hit;
    logic                  w_trig;
    logic [ADDR_WIDTH-1:0] w_post_len;

    // arm pre-empts everything, so a sample or read coinciding with arm is discarded
    assign w_capturing = (r_state == S_PRE_FILL) || (r_state == S_WAIT_TRIG) || (r_state == S_POST);
    assign w_accept    = bus.s_valid && w_capturing && !bus.arm;
    assign w_rd_fire   = bus.rd_en && (r_state == S_DONE) && !bus.arm;

    // A level crossing needs a previous sample; the first sample after arm never qualifies
    assign w_level_hit = r_prev_valid &&
                         (bus.trig_slope ? ((r_prev > bus.trig_level) && (bus.s_data <= bus.trig_level))
                                         : ((r_prev < bus.trig_level) && (bus.s_data >= bus.trig_level)));
    assign w_trig      = w_accept && (r_state == S_WAIT_TRIG) &&
                         (w_level_hit || r_force_pend || bus.force_trig);

    // Samples still to take after the trigger sample: DEPTH-1-pretrig
    assign w_post_len  = {ADDR_WIDTH{1'b1}} - bus.pretrig;

    // Single-port sample RAM: writes only while capturing, reads only in DONE
    always_ff @(posedge ACLK) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.s_data;
        end else if (w_rd_fire) begin
            r_rd_q <= r_mem[r_rd_ptr];
        end
    end

    // Capture/readout controller with registered status outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_trig_ptr   <= '0;
            r_cnt        <= '0;
            r_post_rem   <= '0;
            r_rd_cnt     <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_force_pend <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;

            if (w_accept) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_prev       <= bus.s_data;
                r_prev_valid <= 1'b1;
            end

            if (bus.arm) begin
                // wr_ptr is kept so the ring simply continues from where it was
                r_cnt        <= '0;
                r_post_rem   <= '0;
                r_rd_cnt     <= '0;
                r_triggered  <= 1'b0;
                r_done       <= 1'b0;
                r_prev_valid <= 1'b0;
                r_force_pend <= 1'b0;
                r_busy       <= 1'b1;
                r_state      <= (bus.pretrig == '0) ? S_WAIT_TRIG : S_PRE_FILL;
            end else begin
                case (r_state)
                    S_PRE_FILL: begin
                        if (w_accept) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (({1'b0, r_cnt} + 1'b1) == {1'b0, bus.pretrig}) begin
                                r_state <= S_WAIT_TRIG;
                            end
                        end
                    end
                    S_WAIT_TRIG: begin
                        if (w_trig) begin
                            r_trig_ptr   <= r_wr_ptr;
                            r_triggered  <= 1'b1;
                            r_force_pend <= 1'b0;
                            r_post_rem   <= w_post_len;
                            if (w_post_len == '0) begin
                                r_state  <= S_DONE;
                                r_rd_ptr <= r_wr_ptr - bus.pretrig;
                                r_rd_cnt <= '0;
                                r_done   <= 1'b1;
                                r_busy   <= 1'b0;
                            end else begin
                                r_state <= S_POST;
                            end
                        end else if (bus.force_trig) begin
                            // remember the forced trigger until a sample arrives
                            r_force_pend <= 1'b1;
                        end
                    end
                    S_POST: begin
                        if (w_accept) begin
                            r_post_rem <= r_post_rem - 1'b1;
                            if (r_post_rem == ADDR_WIDTH'(1)) begin
                                r_state  <= S_DONE;
                                r_rd_ptr <= r_trig_ptr - bus.pretrig;
                                r_rd_cnt <= '0;
                                r_done   <= 1'b1;
                                r_busy   <= 1'b0;
                            end
                        end
                    end
                    S_DONE: begin
                        if (w_rd_fire) begin
                            r_rd_valid <= 1'b1;
                            r_rd_last  <= (r_rd_cnt == {ADDR_WIDTH{1'b1}});
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                            r_rd_cnt   <= r_rd_cnt + 1'b1;
                            if (r_rd_cnt == {ADDR_WIDTH{1'b1}}) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // RAM output register carries no reset, so mask it outside valid words
    assign bus.rd_data   = r_rd_valid ? r_rd_q : '0;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_last   = r_rd_last;
    assign bus.busy      = r_busy;
    assign bus.triggered = r_triggered;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_osc_trigger_capture.sv
module tb_osc_trigger_capture;
    localparam int DW    = 12;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b0;

    always #5 ACLK = ~ACLK;

    osc_trigger_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    osc_trigger_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus_if)
    );

    typedef struct {
        int data;
        int last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every readout word is matched against the queue
    always @(negedge ACLK) begin
        if (bus_if.rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rd_valid: got word %0d, expected no word", bus_if.rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd_data", int'(bus_if.rd_data), mon_e.data);
                chk("rd_last", int'(bus_if.rd_last), mon_e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input int v);
        bus_if.s_data  = DW'(v);
        bus_if.s_valid = 1'b1;
        @(negedge ACLK);
        bus_if.s_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        bus_if.arm = 1'b1;
        @(negedge ACLK);
        bus_if.arm = 1'b0;
    endtask

    task automatic config_trig(input int pt, input int lvl, input int slope);
        bus_if.pretrig    = AW'(pt);
        bus_if.trig_level = DW'(lvl);
        bus_if.trig_slope = slope[0];
    endtask

    task automatic read_burst(input int n);
        for (int i = 0; i < n; i++) begin
            bus_if.rd_en = 1'b1;
            @(negedge ACLK);
        end
        bus_if.rd_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge ACLK);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic push_exp(input int d, input int l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    initial begin
        bus_if.s_valid    = 1'b0;
        bus_if.s_data     = '0;
        bus_if.arm        = 1'b0;
        bus_if.force_trig = 1'b0;
        bus_if.trig_level = '0;
        bus_if.trig_slope = 1'b0;
        bus_if.pretrig    = '0;
        bus_if.rd_en      = 1'b0;

        repeat (3) @(negedge ACLK);
        chk("reset_busy", int'(bus_if.busy), 0);
        chk("reset_triggered", int'(bus_if.triggered), 0);
        chk("reset_done", int'(bus_if.done), 0);
        chk("reset_rd_valid", int'(bus_if.rd_valid), 0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // rd_en while IDLE must not produce a word
        bus_if.rd_en = 1'b1;
        @(negedge ACLK);
        bus_if.rd_en = 1'b0;
        chk("idle_rd_ignored", int'(bus_if.rd_valid), 0);

        // Rising trigger on a ramp 0,10,20...; trigger lands on 100
        config_trig(4, 100, 0);
        pulse_arm();
        chk("t1_busy_after_arm", int'(bus_if.busy), 1);
        for (int i = 0; i < 22; i++) begin
            send(10 * i);
            if (i == 9)  chk("t1_not_trig_before_100", int'(bus_if.triggered), 0);
            if (i == 10) chk("t1_trig_on_100", int'(bus_if.triggered), 1);
        end
        chk("t1_done", int'(bus_if.done), 1);
        chk("t1_busy_clear", int'(bus_if.busy), 0);
        for (int i = 0; i < DEPTH; i++) push_exp(60 + 10 * i, (i == DEPTH - 1) ? 1 : 0);
        read_burst(DEPTH);
        drain("t1_drain");
        chk("t1_done_after_read", int'(bus_if.done), 0);

        // Falling trigger after a long flat run: window slides, trigger on 500
        config_trig(8, 500, 1);
        pulse_arm();
        for (int i = 0; i < 30; i++) send(800);
        for (int k = 1; k <= 37; k++) begin
            send(800 - 10 * k);
            if (k == 29) chk("t2_not_trig_at_510", int'(bus_if.triggered), 0);
            if (k == 30) chk("t2_trig_at_500", int'(bus_if.triggered), 1);
        end
        chk("t2_done", int'(bus_if.done), 1);
        for (int i = 0; i < DEPTH; i++) push_exp(580 - 10 * i, (i == DEPTH - 1) ? 1 : 0);
        read_burst(DEPTH);
        drain("t2_drain");

        // Forced trigger with no pre-trigger history
        config_trig(0, 500, 1);
        pulse_arm();
        chk("t3_busy", int'(bus_if.busy), 1);
        bus_if.force_trig = 1'b1;
        @(negedge ACLK);
        bus_if.force_trig = 1'b0;
        @(negedge ACLK);
        chk("t3_force_held_no_sample", int'(bus_if.triggered), 0);
        for (int i = 0; i < DEPTH; i++) begin
            send(42);
            if (i == 0) chk("t3_trig_first_sample", int'(bus_if.triggered), 1);
        end
        chk("t3_done", int'(bus_if.done), 1);
        chk("t3_triggered", int'(bus_if.triggered), 1);
        for (int i = 0; i < DEPTH; i++) push_exp(42, (i == DEPTH - 1) ? 1 : 0);
        read_burst(DEPTH);
        drain("t3_drain");

        // First sample after arm cannot level-trigger
        config_trig(0, 50, 0);
        pulse_arm();
        send(60);
        send(70);
        chk("t4_no_trig", int'(bus_if.triggered), 0);
        chk("t4_busy", int'(bus_if.busy), 1);
        chk("t4_done", int'(bus_if.done), 0);

        // Asynchronous reset in the middle of POST
        config_trig(2, 100, 0);
        pulse_arm();
        for (int i = 0; i < 13; i++) send(10 * i);
        chk("t5_in_post_trig", int'(bus_if.triggered), 1);
        chk("t5_in_post_busy", int'(bus_if.busy), 1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("t5_rst_busy", int'(bus_if.busy), 0);
        chk("t5_rst_triggered", int'(bus_if.triggered), 0);
        chk("t5_rst_done", int'(bus_if.done), 0);
        chk("t5_rst_rd_valid", int'(bus_if.rd_valid), 0);
        chk("t5_rst_rd_last", int'(bus_if.rd_last), 0);
        chk("t5_rst_rd_data", int'(bus_if.rd_data), 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        pulse_arm();
        for (int i = 0; i < 24; i++) send(10 * i);
        chk("t5_done_after_rearm", int'(bus_if.done), 1);

        // Re-arm during readout: arm beats the coincident rd_en
        for (int i = 0; i < 5; i++) push_exp(80 + 10 * i, 0);
        read_burst(5);
        bus_if.arm   = 1'b1;
        bus_if.rd_en = 1'b1;
        @(negedge ACLK);
        bus_if.arm   = 1'b0;
        bus_if.rd_en = 1'b0;
        chk("t6_done_clear", int'(bus_if.done), 0);
        chk("t6_busy_set", int'(bus_if.busy), 1);
        @(negedge ACLK);
        chk("t6_no_rd_valid", int'(bus_if.rd_valid), 0);
        drain("t6_drain");

        repeat (2) @(negedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
